// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the execute-stage branch resolver: funct3 codes,
// BHT counter type, its reset value and the saturating counter step.
package branch_resolve_unit_pkg;

    typedef logic [1:0] bht_ctr_t;

    localparam bht_ctr_t   BHT_RESET_VAL = 2'b01;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    function automatic bht_ctr_t ctr_next(input bht_ctr_t c, input logic taken);
        bht_ctr_t n;
        n = c;
        if (taken && c != 2'b11)
            n = c + 2'b01;
        else if (!taken && c != 2'b00)
            n = c - 2'b01;
        return n;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_bht_2bit.sv
// Untagged table of 2-bit saturating counters: async read for fetch,
// sync update from execute, whole table reset to weakly not-taken.
module bht_2bit
    import branch_resolve_unit_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int BHT_ENTRIES = 64,
    parameter int BHT_IDX_LO  = 2
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [XLEN-1:0] i_rd_pc,
    output logic            o_rd_taken,
    input  logic            i_upd_en,
    input  logic [XLEN-1:0] i_upd_pc,
    input  logic            i_upd_taken
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    bht_ctr_t          r_ctr [BHT_ENTRIES];
    logic [IDX_W-1:0]  w_rd_idx;
    logic [IDX_W-1:0]  w_upd_idx;
    logic              w_unused_pc_bits;

    assign w_rd_idx         = i_rd_pc[BHT_IDX_LO +: IDX_W];
    assign w_upd_idx        = i_upd_pc[BHT_IDX_LO +: IDX_W];
    assign w_unused_pc_bits = ^{i_rd_pc, i_upd_pc};

    // Read sees the pre-edge counter, so a same-cycle update is invisible until next cycle.
    assign o_rd_taken = r_ctr[w_rd_idx][1];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < BHT_ENTRIES; i++)
                r_ctr[i] <= BHT_RESET_VAL;
        end else if (i_upd_en) begin
            r_ctr[w_upd_idx] <= ctr_next(r_ctr[w_upd_idx], i_upd_taken);
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolver: RV64I conditional branches, JAL and JALR,
// registered redirect/exception outputs and BHT training. Optional counters: BRU_STATS_EN.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int BHT_ENTRIES = 64,
    parameter int BHT_IDX_LO  = 2
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [XLEN-1:0] i_fetch_pc,
    output logic            o_pred_taken,
    input  logic            i_valid_in,
    input  logic            i_flush_in,
    input  logic            i_branch,
    input  logic            i_jump,
    input  logic            i_jalr,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_imm,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    input  logic            i_pred_taken_in,
    output logic            o_redirect_valid,
    output logic [XLEN-1:0] o_redirect_pc,
    output logic [XLEN-1:0] o_link_addr,
    output logic            o_misalign_exc,
    output logic            o_illegal_br
`ifdef BRU_STATS_EN
   ,output logic [31:0]     o_stat_branches,
    output logic [31:0]     o_stat_mispredicts
`endif
);

    logic            w_one_kind, w_resolve, w_legal, w_cond, w_taken;
    logic            w_misalign, w_redirect, w_bht_upd;
    logic [XLEN-1:0] w_target, w_pc4, w_redirect_pc;

    logic            r_redirect_valid, r_misalign_exc, r_illegal_br;
    logic [XLEN-1:0] r_redirect_pc, r_link_addr;

    assign w_one_kind = ({i_branch, i_jump, i_jalr} == 3'b100) ||
                        ({i_branch, i_jump, i_jalr} == 3'b010) ||
                        ({i_branch, i_jump, i_jalr} == 3'b001);
    assign w_resolve  = i_valid_in & ~i_flush_in & w_one_kind;
    assign w_legal    = (i_funct3 != 3'b010) && (i_funct3 != 3'b011);

    always_comb begin
        w_cond = 1'b0;
        case (i_funct3)
            F3_BEQ:  w_cond = (i_rs1_data == i_rs2_data);
            F3_BNE:  w_cond = (i_rs1_data != i_rs2_data);
            F3_BLT:  w_cond = ($signed(i_rs1_data) <  $signed(i_rs2_data));
            F3_BGE:  w_cond = ($signed(i_rs1_data) >= $signed(i_rs2_data));
            F3_BLTU: w_cond = (i_rs1_data <  i_rs2_data);
            F3_BGEU: w_cond = (i_rs1_data >= i_rs2_data);
            default: w_cond = 1'b0;
        endcase
    end

    assign w_target      = i_jalr ? ((i_rs1_data + i_imm) & ~{{(XLEN-1){1'b0}}, 1'b1})
                                  : (i_pc + i_imm);
    assign w_pc4         = i_pc + {{(XLEN-3){1'b0}}, 3'd4};
    assign w_taken       = i_branch ? (w_legal & w_cond) : 1'b1;
    assign w_misalign    = w_taken & (w_target[1:0] != 2'b00);
    // Jumps always redirect since fetch has no target predictor.
    assign w_redirect    = ~w_misalign & (i_branch ? (w_legal & (w_taken != i_pred_taken_in)) : 1'b1);
    assign w_redirect_pc = w_taken ? w_target : w_pc4;
    assign w_bht_upd     = w_resolve & i_branch & w_legal & ~w_misalign;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_link_addr      <= '0;
            r_misalign_exc   <= 1'b0;
            r_illegal_br     <= 1'b0;
        end else begin
            r_redirect_valid <= w_resolve & w_redirect;
            r_redirect_pc    <= w_resolve ? w_redirect_pc : '0;
            r_misalign_exc   <= w_resolve & w_misalign;
            r_illegal_br     <= w_resolve & i_branch & ~w_legal;
            if (w_resolve && !i_branch)
                r_link_addr <= w_pc4;
        end
    end

    bht_2bit #(
        .XLEN        (XLEN),
        .BHT_ENTRIES (BHT_ENTRIES),
        .BHT_IDX_LO  (BHT_IDX_LO)
    ) u_bht (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_rd_pc     (i_fetch_pc),
        .o_rd_taken  (o_pred_taken),
        .i_upd_en    (w_bht_upd),
        .i_upd_pc    (i_pc),
        .i_upd_taken (w_taken)
    );

    assign o_redirect_valid = r_redirect_valid;
    assign o_redirect_pc    = r_redirect_pc;
    assign o_link_addr      = r_link_addr;
    assign o_misalign_exc   = r_misalign_exc;
    assign o_illegal_br     = r_illegal_br;

`ifdef BRU_STATS_EN
    logic [31:0] r_stat_branches, r_stat_mispredicts;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_stat_branches    <= '0;
            r_stat_mispredicts <= '0;
        end else if (w_resolve && i_branch && w_legal) begin
            r_stat_branches <= r_stat_branches + 32'd1;
            if (w_redirect)
                r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
        end
    end

    assign o_stat_branches    = r_stat_branches;
    assign o_stat_mispredicts = r_stat_mispredicts;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed test-plan sequences then
// random traffic, checked against a behavioural model of the resolver and BHT.
module tb_branch_resolve_unit;

    typedef struct {
        logic        rv;
        logic [63:0] rpc;
        logic [63:0] link;
        logic        mis;
        logic        ill;
        logic [31:0] sb;
        logic [31:0] sm;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] fetch_pc = '0;
    logic        pred_taken;
    logic        valid_in = 0, flush_in = 0, branch = 0, jump = 0, jalr = 0;
    logic [2:0]  funct3 = '0;
    logic [63:0] pc = '0, imm = '0, rs1_data = '0, rs2_data = '0;
    logic        pred_taken_in = 0;
    logic        redirect_valid, misalign_exc, illegal_br;
    logic [63:0] redirect_pc, link_addr;
`ifdef BRU_STATS_EN
    logic [31:0] stat_branches, stat_mispredicts;
`endif

    always #5 clk = ~clk;

    branch_resolve_unit dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_fetch_pc       (fetch_pc),
        .o_pred_taken     (pred_taken),
        .i_valid_in       (valid_in),
        .i_flush_in       (flush_in),
        .i_branch         (branch),
        .i_jump           (jump),
        .i_jalr           (jalr),
        .i_funct3         (funct3),
        .i_pc             (pc),
        .i_imm            (imm),
        .i_rs1_data       (rs1_data),
        .i_rs2_data       (rs2_data),
        .i_pred_taken_in  (pred_taken_in),
        .o_redirect_valid (redirect_valid),
        .o_redirect_pc    (redirect_pc),
        .o_link_addr      (link_addr),
        .o_misalign_exc   (misalign_exc),
        .o_illegal_br     (illegal_br)
`ifdef BRU_STATS_EN
       ,.o_stat_branches    (stat_branches),
        .o_stat_mispredicts (stat_mispredicts)
`endif
    );

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    // Reference state: counter values 0..3 per table slot, link register, stats.
    int          m_bht[64];
    logic [63:0] m_link = '0;
    int unsigned m_sb = 0, m_sm = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int slot(input logic [63:0] a);
        return int'((a >> 2) % 64);
    endfunction

    // One cycle of stimulus: drive at the falling edge, check the combinational
    // prediction against the pre-edge table, then advance the model for the next edge.
    task automatic drive(input logic rst, input logic v, input logic fl,
                         input logic br, input logic jp, input logic jr,
                         input logic [2:0] f3, input logic [63:0] p, input logic [63:0] im,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic pti, input logic [63:0] fpc);
        exp_t        e;
        longint      sa, sbv;
        logic        taken, legal, resolves;
        logic [63:0] tgt;
        @(negedge clk);
        reset = rst; valid_in = v; flush_in = fl; branch = br; jump = jp; jalr = jr;
        funct3 = f3; pc = p; imm = im; rs1_data = a; rs2_data = b;
        pred_taken_in = pti; fetch_pc = fpc;
        #1;
        chk("pred_taken", {63'd0, pred_taken}, {63'd0, m_bht[slot(fpc)] >= 2});

        e = '{rv: 0, rpc: 0, link: m_link, mis: 0, ill: 0, sb: m_sb, sm: m_sm};
        if (rst) begin
            foreach (m_bht[i]) m_bht[i] = 1;
            m_link = '0; m_sb = 0; m_sm = 0;
            e = '{rv: 0, rpc: 0, link: 0, mis: 0, ill: 0, sb: 0, sm: 0};
        end else begin
            resolves = v && !fl && (int'(br) + int'(jp) + int'(jr) == 1);
            if (resolves) begin
                sa = a; sbv = b;
                legal = 1;
                taken = 1;
                if (br) begin
                    case (f3)
                        3'd0: taken = (a == b);
                        3'd1: taken = (a != b);
                        3'd4: taken = (sa < sbv);
                        3'd5: taken = !(sa < sbv);
                        3'd6: taken = (a < b);
                        3'd7: taken = !(a < b);
                        default: begin taken = 0; legal = 0; end
                    endcase
                end
                tgt = jr ? ((a + im) & ~64'd1) : (p + im);
                e.rpc = taken ? tgt : p + 64'd4;
                e.ill = br && !legal;
                e.mis = taken && (tgt % 4 != 0);
                if (e.mis)      e.rv = 0;
                else if (br)    e.rv = legal && (taken != pti);
                else            e.rv = 1;
                if (!br) begin
                    m_link = p + 64'd4;
                    e.link = m_link;
                end
                if (br && legal) begin
                    m_sb++;
                    if (e.rv) m_sm++;
                    e.sb = m_sb; e.sm = m_sm;
                    if (!e.mis) begin
                        if (taken)  m_bht[slot(p)] = (m_bht[slot(p)] == 3) ? 3 : m_bht[slot(p)] + 1;
                        else        m_bht[slot(p)] = (m_bht[slot(p)] == 0) ? 0 : m_bht[slot(p)] - 1;
                    end
                end
            end
        end
        sb_q.push_back(e);
    endtask

    task automatic idle(input logic [63:0] fpc);
        drive(0, 0, 0, 0, 0, 0, 3'd0, 64'd0, 64'd0, 64'd0, 64'd0, 0, fpc);
    endtask

    // Monitor: outputs registered on each rising edge are compared against the
    // oldest pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("redirect_valid", {63'd0, redirect_valid}, {63'd0, e.rv});
                chk("redirect_pc", redirect_pc, e.rpc);
                chk("link_addr", link_addr, e.link);
                chk("misalign_exc", {63'd0, misalign_exc}, {63'd0, e.mis});
                chk("illegal_br", {63'd0, illegal_br}, {63'd0, e.ill});
`ifdef BRU_STATS_EN
                chk("stat_branches", {32'd0, stat_branches}, {32'd0, e.sb});
                chk("stat_mispredicts", {32'd0, stat_mispredicts}, {32'd0, e.sm});
`endif
            end
        end
    end

    function automatic logic [63:0] pick_opnd();
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return 64'd1;
            2: return 64'd5;
            3: return 64'hFFFF_FFFF_FFFF_FFFF;
            4: return 64'h8000_0000_0000_0000;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        logic [63:0] rp, ri, ra, rb;
        logic [2:0]  kind;
        foreach (m_bht[i]) m_bht[i] = 1;

        // Reset, then BEQ taken with not-taken prediction at 0x100.
        drive(1, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 64'h100);
        drive(1, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 64'h100);
        idle(64'h100);
        drive(0, 1, 0, 1, 0, 0, 3'd0, 64'h100, 64'h20, 64'd5, 64'd5, 0, 64'h100);
        idle(64'h100);
        // Signed vs unsigned compare of -1 and 1.
        drive(0, 1, 0, 1, 0, 0, 3'd4, 64'h200, 64'h40, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 64'h200);
        drive(0, 1, 0, 1, 0, 0, 3'd6, 64'h200, 64'h40, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1, 64'h200);
        // JALR: misaligned target, then aligned after bit-0 clear.
        drive(0, 1, 0, 0, 0, 1, 3'd0, 64'h300, 64'd0, 64'h2003, 64'd0, 0, 64'h300);
        drive(0, 1, 0, 0, 0, 1, 3'd0, 64'h300, 64'd0, 64'h2001, 64'd0, 0, 64'h300);
        idle(64'h400);
        // Saturation up then down; fetch reads the same slot during each update.
        repeat (3) drive(0, 1, 0, 1, 0, 0, 3'd1, 64'h400, 64'h10, 64'd1, 64'd2, 0, 64'h400);
        repeat (2) drive(0, 1, 0, 1, 0, 0, 3'd1, 64'h400, 64'h10, 64'd3, 64'd3, 1, 64'h400);
        idle(64'h400);
        // Illegal funct3, flushed instruction, multiple kinds set.
        drive(0, 1, 0, 1, 0, 0, 3'd2, 64'h400, 64'h10, 64'd3, 64'd3, 1, 64'h400);
        drive(0, 1, 1, 1, 0, 0, 3'd0, 64'h400, 64'h10, 64'd3, 64'd3, 0, 64'h400);
        drive(0, 1, 0, 1, 1, 0, 3'd0, 64'h400, 64'h10, 64'd3, 64'd3, 0, 64'h400);
        drive(0, 1, 0, 0, 1, 0, 3'd0, 64'h500, 64'hFFFF_FFFF_FFFF_FFF0, 64'd0, 64'd0, 0, 64'h400);
        // Reset colliding with a mispredicted BGE.
        drive(1, 1, 0, 1, 0, 0, 3'd5, 64'h400, 64'h10, 64'd7, 64'd3, 0, 64'h400);
        idle(64'h400);
        // Four branches, one mispredicted.
        drive(0, 1, 0, 1, 0, 0, 3'd0, 64'h600, 64'h8, 64'd1, 64'd2, 0, 64'h600);
        drive(0, 1, 0, 1, 0, 0, 3'd7, 64'h604, 64'h8, 64'd9, 64'd2, 1, 64'h600);
        drive(0, 1, 0, 1, 0, 0, 3'd6, 64'h608, 64'h8, 64'd9, 64'd2, 0, 64'h600);
        drive(0, 1, 0, 1, 0, 0, 3'd1, 64'h60C, 64'h8, 64'd1, 64'd2, 0, 64'h600);
        idle(64'h600);

        for (int n = 0; n < 600; n++) begin
            rp   = 64'h1000 + 64'(4 * $urandom_range(0, 15)) + 64'(256 * $urandom_range(0, 1));
            ri   = ($urandom_range(0, 7) == 0) ? 64'($urandom_range(0, 15))
                                               : 64'(4 * ($urandom_range(0, 31) - 16));
            ra   = pick_opnd();
            rb   = ($urandom_range(0, 3) == 0) ? ra : pick_opnd();
            kind = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(0, 7))
                 : (3'b100 >> $urandom_range(0, 2));
            if ($urandom_range(0, 2) == 0) kind = 3'b100;
            drive($urandom_range(0, 60) == 0, $urandom_range(0, 5) != 0,
                  $urandom_range(0, 9) == 0, kind[2], kind[1], kind[0],
                  3'($urandom_range(0, 7)), rp, ri, ra, rb, 1'($urandom_range(0, 1)),
                  64'h1000 + 64'(4 * $urandom_range(0, 15)));
        end

        idle(64'h0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d want=0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Execute-stage branch resolver, replacing the BEQ/BNE-only comparator. Covers:
- all six RV64I conditional branches, plus JAL and JALR;
- a BHT of 2-bit saturating counters that the fetch stage reads for direction prediction;
- a registered redirect/flush decision, produced one cycle after resolve, when the resolved direction differs from the prediction carried with the instruction.

Parameters:
- XLEN, 64, datapath and address width.
- BHT_ENTRIES, 64, number of 2-bit counters; power of two, at least 2.
- BHT_IDX_LO, 2, lowest PC bit used for the BHT index; index = pc[BHT_IDX_LO +: log2(BHT_ENTRIES)].

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- fetch_pc  in  XLEN  PC being fetched, for prediction lookup.
- pred_taken  out  1  combinational BHT prediction for fetch_pc (counter MSB).
- valid_in  in  1  EX-stage instruction valid.
- flush_in  in  1  kill the instruction in EX (older exception); suppresses all effects.
- branch  in  1  conditional branch.
- jump  in  1  JAL.
- jalr  in  1  JALR.
- funct3  in  3  branch type.
- pc  in  XLEN  EX instruction PC.
- imm  in  XLEN  sign-extended immediate.
- rs1_data, rs2_data  in  XLEN  operands.
- pred_taken_in  in  1  prediction carried down the pipe with the instruction.
- redirect_valid  out  1  registered; fetch must restart at redirect_pc.
- redirect_pc  out  XLEN  registered restart address.
- link_addr  out  XLEN  registered pc+4 for JAL/JALR writeback.
- misalign_exc  out  1  registered; taken target has bits [1:0] != 0.
- illegal_br  out  1  registered; branch with funct3 010 or 011.

Behaviour:
- Reset: all registered outputs are 0. Every BHT counter becomes 2'b01 (weakly not-taken), written in a single cycle.
- Resolve happens when valid_in & ~flush_in & exactly one of branch/jump/jalr is set. If more than one is set, nothing resolves and no state changes.
- Condition by funct3:
  - 000 BEQ, 001 BNE.
  - 100 BLT, 101 BGE (signed, XLEN-wide).
  - 110 BLTU, 111 BGEU (unsigned).
  - 010/011: not taken, no BHT update, illegal_br=1 for one cycle.
- Targets:
  - branch and JAL: pc+imm, wrapping modulo 2^XLEN.
  - JALR: (rs1_data+imm) with bit 0 cleared.
- actual_taken = condition result for branches; 1 for JAL/JALR.
- Redirect rules:
  - Branch: redirect_valid = (actual_taken != pred_taken_in). redirect_pc = actual_taken ? target : pc+4.
  - JAL/JALR: always redirect to target; there is no BTB.
- Misalignment: if actual_taken and target[1:0] != 0, then misalign_exc=1, redirect_valid=0 and the BHT is not updated. No implicit 2'b00 masking of targets.
- Latency: all outputs register on the clock edge after resolve and hold for exactly one cycle, then return to 0. link_addr holds its last value.
- BHT update on the same edge, conditional branches only, legal funct3, not misaligned:
  - taken: counter increments, saturating at 11;
  - not taken: counter decrements, saturating at 00.
- Same-cycle lookup and update of one index: pred_taken returns the pre-update value (read-before-write).
- Index aliasing between different PCs is permitted, with no tags.
- flush_in together with valid_in: no outputs and no BHT change.
- reset asserted mid-operation wins over any resolve in that cycle.
- No $display or other simulation prints in synthesizable code.

Optional Feature:
Macro BRU_STATS_EN.
- Defined: adds outputs stat_branches and stat_mispredicts, each 32 bits. They count resolved legal conditional branches and those with redirect_valid=1, wrap at 2^32, and clear on reset.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - funct3 constants: F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU;
  - the BHT reset value 2'b01;
  - the 2-bit counter type.
- Sub-module bht_2bit, parametrised by BHT_ENTRIES and BHT_IDX_LO. It provides one async read port and one sync update port, plus reset-to-weak-NT.
- Compare/target logic stays in the top module.

Test Plan:
1. Reset, then fetch_pc=0x100 → pred_taken=0. BEQ at pc=0x100, rs1=rs2=5, imm=0x20, pred_taken_in=0 → next cycle redirect_valid=1, redirect_pc=0x120. Counter at that index becomes 10, so pred_taken=1.
2. BLT with rs1=0xFFFF_FFFF_FFFF_FFFF and rs2=1 → taken. Same operands with BLTU → not taken. With pred_taken_in=1 → redirect_pc=pc+4.
3. JALR with rs1=0x2003, imm=0 → redirect_pc=0x2002, misalign_exc=1, redirect_valid=0. JALR with rs1=0x2001 → redirect_pc=0x2000, link_addr=pc+4.
4. Three taken BNE at one PC → counter saturates at 11. Two not-taken → counter at 01 and pred_taken=0. A same-cycle lookup during an update returns the old value.
5. funct3=010 with branch=1 → illegal_br=1, no redirect, BHT unchanged. valid_in=1 with flush_in=1 → all outputs 0.
6. reset asserted in the same cycle as a mispredicted BGE → outputs 0 and the BHT reinitialised to 01. With BRU_STATS_EN defined, 4 branches including 1 mispredict → stat_branches=4, stat_mispredicts=1.
